uart_core: RTL and testbench
============================

UART_CORE -- requirements
Module: uart_core

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data bits per frame (legal 5..9).
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, clk cycles per bit (legal >=4, even).
REQ-003 SHALL have parameter STOP_BITS, default 1, stop bits sent (legal 1 or 2).
REQ-004 SHALL have parameter PARITY_ODD, default 0, parity sense (0 even, 1 odd).
REQ-005 SHALL have port clk, input, 1, the single clock.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port loopback, input, 1, routes internal TX to RX when high.
REQ-008 SHALL have port tx_start, input, 1, request to send tx_data.
REQ-009 SHALL have port tx_data, input, DATA_W, word to transmit.
REQ-010 SHALL have port tx, output, 1, serial line out, idle high.
REQ-011 SHALL have port tx_busy, output, 1, transmitter occupied.
REQ-012 SHALL have port rx, input, 1, serial line in, asynchronous.
REQ-013 SHALL have port rx_data, output, DATA_W, last received word.
REQ-014 SHALL have port rx_done, output, 1, one-cycle pulse per received frame.
REQ-015 SHALL have port rx_err, output, 1, framing/parity error of last frame.

Function
REQ-016 TX FSM SHALL use states IDLE, START, DATA, PARITY, STOP, each bit held exactly CLKS_PER_BIT cycles, data LSB first.
REQ-017 tx_start SHALL be accepted only when tx_busy=0; tx_data captured on accept; tx_start while busy ignored, no queuing.
REQ-018 tx_busy SHALL rise the cycle after accept and fall after the last stop bit's final cycle; back-to-back accept allowed that same cycle.
REQ-019 While loopback=1 the tx port SHALL be held 1 and RX SHALL sample the internal TX line instead of rx.
REQ-020 External rx SHALL pass a two-flop synchroniser before use; loopback path bypasses it.
REQ-021 RX FSM SHALL use states IDLE, START, DATA, PARITY, STOP; falling edge in IDLE enters START.
REQ-022 RX SHALL sample at CLKS_PER_BIT/2 into START; sample 1 there = false start, return to IDLE, no rx_done.
REQ-023 Data, parity and first stop bit SHALL each be sampled at bit centre; RX checks only one stop bit regardless of STOP_BITS.
REQ-024 At the stop-bit sample: rx_data updated, rx_done pulses one cycle, rx_err = framing (stop=0) OR parity mismatch; rx_err holds until next rx_done.
REQ-025 RX SHALL return to IDLE immediately after the stop sample, so a new start edge in the second half of stop is detected.
REQ-026 Toggling loopback mid-frame SHALL not lock either FSM; that frame's content is undefined.

Reset
REQ-027 rst=1 SHALL asynchronously force both FSMs to IDLE, counters 0, tx=1, tx_busy=0, rx_data=0, rx_done=0, rx_err=0, synchroniser flops=1.
REQ-028 Reset mid-frame SHALL abandon the frame with no rx_done on release.

Configuration
REQ-029 Macro UART_PARITY_EN defined: PARITY state active, one parity bit after data per PARITY_ODD, parity mismatch sets rx_err.
REQ-030 UART_PARITY_EN undefined: PARITY state and logic absent, frame = start+data+stop, rx_err = framing only, PARITY_ODD ignored.

Structure
REQ-031 Package uart_pkg SHALL hold the TX/RX state typedefs and default parameter constants.
REQ-032 Synchroniser SHALL be sub-module uart_sync2; TX and RX remain in uart_core.

Verification
REQ-033 DATA_W=8, CLKS_PER_BIT=16, loopback=1, send 8'hA5 -> one rx_done, rx_data=8'hA5, rx_err=0, tx stays 1, tx_busy high 160 cycles.
REQ-034 External rx drives 0x3C with stop bit forced 0 -> rx_done, rx_data=8'h3C, rx_err=1; next clean 0x55 -> rx_err=0.
REQ-035 UART_PARITY_EN, PARITY_ODD=0, rx frame 0x07 with parity bit 0 -> rx_err=1; parity bit 1 -> rx_err=0.
REQ-036 rx low pulse of 4 cycles -> no rx_done, RX back in IDLE; tx_start pulsed while busy -> ignored, only first word sent.
REQ-037 rst asserted mid-TX at bit 3 -> tx=1, tx_busy=0 same cycle; no rx_done after release in loopback.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and default parameter values for the UART core.
// Build option: define UART_PARITY_EN to add a parity bit after the data bits.
package uart_pkg;

    localparam int DEF_DATA_W       = 8;
    localparam int DEF_CLKS_PER_BIT = 16;
    localparam int DEF_STOP_BITS    = 1;
    localparam int DEF_PARITY_ODD   = 0;

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
`else
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
`endif

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for the asynchronous serial input; resets to line idle (1).
module uart_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    // Shift the raw input through two flops to settle metastability.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_reg <= 1'b1;
            sync_reg <= 1'b1;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/uart_core.sv
// UART transmitter and receiver with internal loopback.
// Build option: define UART_PARITY_EN to send and check a parity bit
// (sense chosen by PARITY_ODD); otherwise frames are start + data + stop.
module uart_core
    import uart_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int STOP_BITS    = DEF_STOP_BITS,
    parameter int PARITY_ODD   = DEF_PARITY_ODD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              loopback,
    input  logic              tx_start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx,
    output logic              tx_busy,
    input  logic              rx,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_done,
    output logic              rx_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_W);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    // Elaboration-time guards on parameter legality.
    if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
        $error("uart_core: DATA_W must be 5..9");
    end
    if (CLKS_PER_BIT < 4 || (CLKS_PER_BIT % 2) != 0) begin : g_bad_clks
        $error("uart_core: CLKS_PER_BIT must be even and >= 4");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_core: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity
        $error("uart_core: PARITY_ODD must be 0 or 1");
    end

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    tx_state_t         tx_state_reg, tx_state_next;
    logic [CW-1:0]     tx_cnt_reg, tx_cnt_next;
    logic [BW-1:0]     tx_bit_reg, tx_bit_next;
    logic [DATA_W-1:0] tx_shift_reg, tx_shift_next;
    logic              tx_stop_reg, tx_stop_next;
    logic              tx_line;
`ifdef UART_PARITY_EN
    logic              tx_par_reg, tx_par_next;
`endif

    // TX state and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_reg <= TX_IDLE;
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= '0;
            tx_shift_reg <= '0;
            tx_stop_reg  <= 1'b0;
`ifdef UART_PARITY_EN
            tx_par_reg   <= 1'b0;
`endif
        end else begin
            tx_state_reg <= tx_state_next;
            tx_cnt_reg   <= tx_cnt_next;
            tx_bit_reg   <= tx_bit_next;
            tx_shift_reg <= tx_shift_next;
            tx_stop_reg  <= tx_stop_next;
`ifdef UART_PARITY_EN
            tx_par_reg   <= tx_par_next;
`endif
        end
    end

    // TX next-state logic and serial line decode; each bit lasts CLKS_PER_BIT cycles.
    always_comb begin
        tx_state_next = tx_state_reg;
        tx_cnt_next   = tx_cnt_reg;
        tx_bit_next   = tx_bit_reg;
        tx_shift_next = tx_shift_reg;
        tx_stop_next  = tx_stop_reg;
`ifdef UART_PARITY_EN
        tx_par_next   = tx_par_reg;
`endif
        tx_line       = 1'b1;
        case (tx_state_reg)
            TX_IDLE: begin
                if (tx_start) begin
                    tx_shift_next = tx_data;
`ifdef UART_PARITY_EN
                    tx_par_next   = (^tx_data) ^ 1'(PARITY_ODD);
`endif
                    tx_cnt_next   = '0;
                    tx_state_next = TX_START;
                end
            end
            TX_START: begin
                tx_line = 1'b0;
                if (tx_cnt_reg == CNT_LAST) begin
                    tx_cnt_next   = '0;
                    tx_bit_next   = '0;
                    tx_state_next = TX_DATA;
                end else begin
                    tx_cnt_next = tx_cnt_reg + 1'b1;
                end
            end
            TX_DATA: begin
                tx_line = tx_shift_reg[0];
                if (tx_cnt_reg == CNT_LAST) begin
                    tx_cnt_next   = '0;
                    tx_shift_next = tx_shift_reg >> 1;
                    if (tx_bit_reg == BIT_LAST) begin
                        tx_stop_next  = 1'b0;
`ifdef UART_PARITY_EN
                        tx_state_next = TX_PARITY;
`else
                        tx_state_next = TX_STOP;
`endif
                    end else begin
                        tx_bit_next = tx_bit_reg + 1'b1;
                    end
                end else begin
                    tx_cnt_next = tx_cnt_reg + 1'b1;
                end
            end
`ifdef UART_PARITY_EN
            TX_PARITY: begin
                tx_line = tx_par_reg;
                if (tx_cnt_reg == CNT_LAST) begin
                    tx_cnt_next   = '0;
                    tx_state_next = TX_STOP;
                end else begin
                    tx_cnt_next = tx_cnt_reg + 1'b1;
                end
            end
`endif
            TX_STOP: begin
                tx_line = 1'b1;
                if (tx_cnt_reg == CNT_LAST) begin
                    tx_cnt_next = '0;
                    if (STOP_BITS == 1 || tx_stop_reg) begin
                        tx_state_next = TX_IDLE;
                    end else begin
                        tx_stop_next = 1'b1;
                    end
                end else begin
                    tx_cnt_next = tx_cnt_reg + 1'b1;
                end
            end
            default: tx_state_next = TX_IDLE;
        endcase
    end

    // The external pin parks high while the frame is routed internally.
    assign tx      = tx_line | loopback;
    assign tx_busy = (tx_state_reg != TX_IDLE);

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic              rx_sync;
    logic              rx_line;
    rx_state_t         rx_state_reg, rx_state_next;
    logic [CW-1:0]     rx_cnt_reg, rx_cnt_next;
    logic [BW-1:0]     rx_bit_reg, rx_bit_next;
    logic [DATA_W-1:0] rx_shift_reg, rx_shift_next;
    logic [DATA_W-1:0] rx_data_reg, rx_data_next;
    logic              rx_done_reg, rx_done_next;
    logic              rx_err_reg, rx_err_next;
    logic              rx_prev_reg;
    logic              rx_par_err;
`ifdef UART_PARITY_EN
    logic              rx_par_err_reg, rx_par_err_next;
`endif

    uart_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_sync)
    );

    // Loopback takes the internal TX line directly; it is already synchronous.
    assign rx_line = loopback ? tx_line : rx_sync;

`ifdef UART_PARITY_EN
    assign rx_par_err = rx_par_err_reg;
`else
    assign rx_par_err = 1'b0;
`endif

    // RX state, datapath and previous-line registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state_reg <= RX_IDLE;
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= '0;
            rx_shift_reg <= '0;
            rx_data_reg  <= '0;
            rx_done_reg  <= 1'b0;
            rx_err_reg   <= 1'b0;
            rx_prev_reg  <= 1'b1;
`ifdef UART_PARITY_EN
            rx_par_err_reg <= 1'b0;
`endif
        end else begin
            rx_state_reg <= rx_state_next;
            rx_cnt_reg   <= rx_cnt_next;
            rx_bit_reg   <= rx_bit_next;
            rx_shift_reg <= rx_shift_next;
            rx_data_reg  <= rx_data_next;
            rx_done_reg  <= rx_done_next;
            rx_err_reg   <= rx_err_next;
            rx_prev_reg  <= rx_line;
`ifdef UART_PARITY_EN
            rx_par_err_reg <= rx_par_err_next;
`endif
        end
    end

    // RX next-state logic: half a bit to the start centre, then whole bits to each centre.
    always_comb begin
        rx_state_next = rx_state_reg;
        rx_cnt_next   = rx_cnt_reg;
        rx_bit_next   = rx_bit_reg;
        rx_shift_next = rx_shift_reg;
        rx_data_next  = rx_data_reg;
        rx_done_next  = 1'b0;
        rx_err_next   = rx_err_reg;
`ifdef UART_PARITY_EN
        rx_par_err_next = rx_par_err_reg;
`endif
        case (rx_state_reg)
            RX_IDLE: begin
                if (rx_prev_reg && !rx_line) begin
                    rx_cnt_next   = '0;
                    rx_state_next = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt_reg == CNT_HALF) begin
                    rx_cnt_next = '0;
                    rx_bit_next = '0;
                    // A high line at the start centre was only a glitch.
                    rx_state_next = rx_line ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_next = rx_cnt_reg + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_reg == CNT_LAST) begin
                    rx_cnt_next   = '0;
                    rx_shift_next = {rx_line, rx_shift_reg[DATA_W-1:1]};
                    if (rx_bit_reg == BIT_LAST) begin
`ifdef UART_PARITY_EN
                        rx_state_next = RX_PARITY;
`else
                        rx_state_next = RX_STOP;
`endif
                    end else begin
                        rx_bit_next = rx_bit_reg + 1'b1;
                    end
                end else begin
                    rx_cnt_next = rx_cnt_reg + 1'b1;
                end
            end
`ifdef UART_PARITY_EN
            RX_PARITY: begin
                if (rx_cnt_reg == CNT_LAST) begin
                    rx_cnt_next     = '0;
                    rx_par_err_next = rx_line ^ (^rx_shift_reg) ^ 1'(PARITY_ODD);
                    rx_state_next   = RX_STOP;
                end else begin
                    rx_cnt_next = rx_cnt_reg + 1'b1;
                end
            end
`endif
            RX_STOP: begin
                if (rx_cnt_reg == CNT_LAST) begin
                    rx_cnt_next   = '0;
                    rx_data_next  = rx_shift_reg;
                    rx_done_next  = 1'b1;
                    rx_err_next   = ~rx_line | rx_par_err;
                    rx_state_next = RX_IDLE;
                end else begin
                    rx_cnt_next = rx_cnt_reg + 1'b1;
                end
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    assign rx_data = rx_data_reg;
    assign rx_done = rx_done_reg;
    assign rx_err  = rx_err_reg;

endmodule

// File: tb/tb_uart_core.sv
// Scoreboard bench for uart_core: expected words are queued when a frame is
// launched and checked when rx_done pulses.
module tb_uart_core;

    localparam int DATA_W = 8;
    localparam int CPB    = 16;
    localparam int STOPS  = 1;
    localparam int PODD   = 0;
`ifdef UART_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int FRAME_BITS = 1 + DATA_W + PAR_BITS + STOPS;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              err;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              loopback = 1'b0;
    logic              tx_start = 1'b0;
    logic [DATA_W-1:0] tx_data = '0;
    logic              tx;
    logic              tx_busy;
    logic              rx_drv = 1'b1;
    logic              ext_loop = 1'b0;
    logic              rx_in;
    logic [DATA_W-1:0] rx_data;
    logic              rx_done;
    logic              rx_err;

    int   checks = 0;
    int   failures = 0;
    int   done_count = 0;
    exp_t sb[$];
    exp_t e;

    assign rx_in = ext_loop ? tx : rx_drv;

    uart_core #(
        .DATA_W       (DATA_W),
        .CLKS_PER_BIT (CPB),
        .STOP_BITS    (STOPS),
        .PARITY_ODD   (PODD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .loopback (loopback),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx       (tx),
        .tx_busy  (tx_busy),
        .rx       (rx_in),
        .rx_data  (rx_data),
        .rx_done  (rx_done),
        .rx_err   (rx_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Receive-side monitor: every rx_done must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && rx_done) begin
            done_count++;
            check("rx_done_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("rx_data", 32'(rx_data), 32'(e.data));
                check("rx_err", 32'(rx_err), 32'(e.err));
                $display("rx frame data=0x%0h err=%0b", rx_data, rx_err);
            end
        end
    end

    task automatic tx_send(input logic [DATA_W-1:0] d);
        int n = 0;
        while (tx_busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("tx_idle_before_send", 32'(tx_busy), 32'd0);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        $display("tx send data=0x%0h loopback=%0b", d, loopback);
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] d, input logic stop_val, input logic par_val);
        rx_drv = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < DATA_W; i++) begin
            rx_drv = d[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef UART_PARITY_EN
        rx_drv = par_val;
        repeat (CPB) @(negedge clk);
`endif
        rx_drv = stop_val;
        repeat (CPB) @(negedge clk);
        rx_drv = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        $display("rx drive data=0x%0h stop=%0b par=%0b", d, stop_val, par_val);
    endtask

    task automatic wait_sb_empty(input string tag, input int max_cycles);
        int n = 0;
        while (sb.size() != 0 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(sb.size()), 32'd0);
    endtask

    function automatic logic good_par(input logic [DATA_W-1:0] d);
        return (^d) ^ 1'(PODD);
    endfunction

    initial begin
        int n;
        int d0;
        logic tx_low;
        logic [DATA_W-1:0] w;
        logic [FRAME_BITS-1:0] bits;

        // Reset values
        repeat (3) @(negedge clk);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_tx_busy", 32'(tx_busy), 32'd0);
        check("reset_rx_data", 32'(rx_data), 32'd0);
        check("reset_rx_done", 32'(rx_done), 32'd0);
        check("reset_rx_err", 32'(rx_err), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Loopback 0xA5: tx pin stays high, busy lasts one full frame
        loopback = 1'b1;
        d0 = done_count;
        sb.push_back('{data: 8'hA5, err: 1'b0});
        tx_send(8'hA5);
        n = 0;
        tx_low = 1'b0;
        while (tx_busy && n < 1000) begin
            if (tx !== 1'b1) tx_low = 1'b1;
            n++;
            @(negedge clk);
        end
        check("loop_busy_cycles", 32'(n), 32'(CPB * FRAME_BITS));
        check("loop_tx_held_high", 32'(tx_low), 32'd0);
        wait_sb_empty("loop_a5_received", 400);
        check("loop_a5_done_count", 32'(done_count - d0), 32'd1);
        loopback = 1'b0;
        repeat (CPB) @(negedge clk);

        // External 0x3C with a broken stop bit, then a clean 0x55
        sb.push_back('{data: 8'h3C, err: 1'b1});
        send_frame(8'h3C, 1'b0, good_par(8'h3C));
        wait_sb_empty("ext_3c_received", 100);
        check("err_holds", 32'(rx_err), 32'd1);
        check("data_holds", 32'(rx_data), 32'h3C);
        sb.push_back('{data: 8'h55, err: 1'b0});
        send_frame(8'h55, 1'b1, good_par(8'h55));
        wait_sb_empty("ext_55_received", 100);

`ifdef UART_PARITY_EN
        // Parity: 0x07 has three ones, so even parity wants a 1
        sb.push_back('{data: 8'h07, err: 1'b1});
        send_frame(8'h07, 1'b1, 1'b0);
        wait_sb_empty("par_bad_received", 100);
        sb.push_back('{data: 8'h07, err: 1'b0});
        send_frame(8'h07, 1'b1, 1'b1);
        wait_sb_empty("par_good_received", 100);
`endif

        // Short low glitch must not produce a frame; RX must still work afterwards
        d0 = done_count;
        rx_drv = 1'b0;
        repeat (4) @(negedge clk);
        rx_drv = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check("glitch_no_done", 32'(done_count - d0), 32'd0);
        sb.push_back('{data: 8'hA3, err: 1'b0});
        send_frame(8'hA3, 1'b1, good_par(8'hA3));
        wait_sb_empty("after_glitch_received", 100);

        // Pin-level TX: sample each bit centre and feed the pin back into rx
        ext_loop = 1'b1;
        w = 8'h5A;
`ifdef UART_PARITY_EN
        bits = {1'b1, good_par(w), w, 1'b0};
`else
        bits = {1'b1, w, 1'b0};
`endif
        sb.push_back('{data: w, err: 1'b0});
        tx_send(w);
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < FRAME_BITS; i++) begin
            check($sformatf("tx_pin_bit%0d", i), 32'(tx), 32'(bits[i]));
            repeat (CPB) @(negedge clk);
        end
        wait_sb_empty("pin_loop_received", 200);
        n = 0;
        while (tx_busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        ext_loop = 1'b0;
        repeat (CPB) @(negedge clk);

        // tx_start while busy is dropped; tx_data is captured on accept only
        loopback = 1'b1;
        d0 = done_count;
        sb.push_back('{data: 8'h96, err: 1'b0});
        tx_send(8'h96);
        repeat (20) @(negedge clk);
        tx_data  = 8'h69;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        n = 0;
        while (tx_busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        repeat (3 * CPB) @(negedge clk);
        check("busy_ignore_idle", 32'(tx_busy), 32'd0);
        wait_sb_empty("busy_ignore_received", 100);
        check("busy_ignore_one_frame", 32'(done_count - d0), 32'd1);

        // Reset in the middle of data bit 3 while looped back
        d0 = done_count;
        tx_send(8'hF0);
        repeat (4 * CPB + CPB / 2) @(negedge clk);
        check("pre_reset_busy", 32'(tx_busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("reset_mid_tx", 32'(tx), 32'd1);
        check("reset_mid_busy", 32'(tx_busy), 32'd0);
        check("reset_mid_rx_done", 32'(rx_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("reset_mid_rx_data", 32'(rx_data), 32'd0);
        check("reset_mid_rx_err", 32'(rx_err), 32'd0);
        repeat (12 * CPB) @(negedge clk);
        check("reset_no_done", 32'(done_count - d0), 32'd0);
        check("reset_still_idle", 32'(tx_busy), 32'd0);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
